// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared types for the RLE blob tracker
//
// Purpose: FSM state enum, coordinate typedefs and the bounding-box struct
// used by rle_blob_tracker.
// Ports: none (package).
package rle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_GAP   = 2'd2,
    ST_CLOSE = 2'd3
  } state_e;

  typedef logic [9:0] xcoord_t;
  typedef logic [8:0] ycoord_t;

  typedef struct packed {
    xcoord_t left;
    xcoord_t right;
    ycoord_t top;
    ycoord_t bottom;
  } box_t;

  // Boxes are only ever built with bottom >= top, so this cannot wrap.
  function automatic ycoord_t box_height(input box_t b);
    return b.bottom - b.top;
  endfunction

endpackage

// File: rtl/rle_blob_tracker.sv
// rtl/rle_blob_tracker.sv - tracks the tallest white blob in a run-length coded frame
//
// Purpose: consumes one (run_start, run_len) pair per line, grows a current
// bounding box over vertically overlapping runs, tolerates short gaps, keeps
// the tallest qualifying box of the frame and publishes it after the last line.
// Optional feature macro: RLE_BLOB_AREA_EN adds bbox_area (sum of clipped run
// lengths of the published blob).
// Ports:
//   CLK, RESET_N            clock, asynchronous active-low reset
//   frame_start             pulse before line 0 (also aborts a frame in progress)
//   line_end                pulse qualifying run_start/run_len for one line
//   run_start, run_len      white run start x and length (len 0 = empty line)
//   bbox_left/right/top/bottom  published box, held between bbox_valid pulses
//   bbox_valid              one-cycle result strobe
//   bbox_found              a qualifying blob was present in the last frame
//   bbox_area               (RLE_BLOB_AREA_EN only) area of the published blob
module rle_blob_tracker
  import rle_pkg::*;
#(
  parameter int IMAGE_W   = 639,
  parameter int IMAGE_H   = 479,
  parameter int GAP_MAX   = 3,
  parameter int MIN_LINES = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        frame_start,
  input  logic        line_end,
  input  logic [9:0]  run_start,
  input  logic [9:0]  run_len,
  output logic [9:0]  bbox_left,
  output logic [9:0]  bbox_right,
  output logic [8:0]  bbox_top,
  output logic [8:0]  bbox_bottom,
  output logic        bbox_valid,
`ifdef RLE_BLOB_AREA_EN
  output logic [18:0] bbox_area,
`endif
  output logic        bbox_found
);

  localparam xcoord_t    X_LAST   = xcoord_t'(IMAGE_W);
  localparam ycoord_t    Y_LAST   = ycoord_t'(IMAGE_H);
  localparam logic [7:0] GAP_LIM  = 8'(GAP_MAX);
  localparam logic [8:0] MIN_HITS = 9'(MIN_LINES);

  state_e     state_q, state_d;
  logic       armed_q, armed_d;
  logic       done_q, done_d;
  logic       fin_q, fin_d;
  ycoord_t    line_q, line_d;
  box_t       cur_q, cur_d;
  box_t       best_q, best_d;
  logic       best_vld_q, best_vld_d;
  logic [8:0] hits_q, hits_d;
  logic [7:0] gap_q, gap_d;
  box_t       out_q, out_d;
  logic       valid_q, valid_d;
  logic       found_q, found_d;
`ifdef RLE_BLOB_AREA_EN
  logic [18:0] cur_area_q, cur_area_d;
  logic [18:0] best_area_q, best_area_d;
  logic [18:0] out_area_q, out_area_d;
  logic [9:0]  run_w;
`endif

  logic        take, hit, overlap, is_open, is_idle, close_now, close_ok;
  logic [10:0] end_x;
  logic [7:0]  gap_inc;
  xcoord_t     x_l, x_r;

  // Lines count only inside an armed, unfinished frame; frame_start wins.
  assign take    = line_end & armed_q & ~done_q & ~frame_start;
  assign end_x   = {1'b0, run_start} + {1'b0, run_len} - 11'd1;
  assign hit     = (run_len != 10'd0) && (run_start <= X_LAST);
  assign x_l     = run_start;
  assign x_r     = (end_x > {1'b0, X_LAST}) ? X_LAST : end_x[9:0];
  assign overlap = (x_l <= cur_q.right) && (x_r >= cur_q.left);
  assign gap_inc = gap_q + 8'd1;
  assign is_open = (state_q == ST_TRACK) || (state_q == ST_GAP);
  // CLOSE behaves like IDLE for a line arriving in the same cycle.
  assign is_idle = (state_q == ST_IDLE) || (state_q == ST_CLOSE);
  // A blob closes either by gap timeout (CLOSE) or at the end of the frame.
  assign close_now = (state_q == ST_CLOSE) || (fin_q && is_open);
  assign close_ok  = close_now && (hits_q >= MIN_HITS) &&
                     (!best_vld_q || (box_height(cur_q) > box_height(best_q)));
`ifdef RLE_BLOB_AREA_EN
  assign run_w = x_r - x_l + 10'd1;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ST_IDLE;
    end else if (take) begin
      if (is_idle)                   state_d = hit ? ST_TRACK : ST_IDLE;
      else if (hit && overlap)       state_d = ST_TRACK;
      else if (gap_inc >= GAP_LIM)   state_d = ST_CLOSE;
      else                           state_d = ST_GAP;
    end else if (close_now) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    line_d     = line_q;
    armed_d    = armed_q;
    done_d     = done_q;
    fin_d      = 1'b0;
    cur_d      = cur_q;
    hits_d     = hits_q;
    gap_d      = gap_q;
    best_d     = best_q;
    best_vld_d = best_vld_q;
    out_d      = out_q;
    found_d    = found_q;
    valid_d    = 1'b0;
`ifdef RLE_BLOB_AREA_EN
    cur_area_d  = cur_area_q;
    best_area_d = best_area_q;
    out_area_d  = out_area_q;
`endif
    if (frame_start) begin
      // Abort/start: drop all frame state but leave the published result alone.
      line_d     = '0;
      armed_d    = 1'b1;
      done_d     = 1'b0;
      cur_d      = '0;
      hits_d     = '0;
      gap_d      = '0;
      best_d     = '0;
      best_vld_d = 1'b0;
`ifdef RLE_BLOB_AREA_EN
      cur_area_d  = '0;
      best_area_d = '0;
`endif
    end else begin
      if (close_ok) begin
        best_d     = cur_q;
        best_vld_d = 1'b1;
`ifdef RLE_BLOB_AREA_EN
        best_area_d = cur_area_q;
`endif
      end
      if (take) begin
        line_d = line_q + 9'd1;
        if (line_q == Y_LAST) begin
          done_d = 1'b1;
          fin_d  = 1'b1;
        end
        if (is_idle) begin
          if (hit) begin
            cur_d.left   = x_l;
            cur_d.right  = x_r;
            cur_d.top    = line_q;
            cur_d.bottom = line_q;
            hits_d       = 9'd1;
            gap_d        = '0;
`ifdef RLE_BLOB_AREA_EN
            cur_area_d   = 19'(run_w);
`endif
          end
        end else if (hit && overlap) begin
          cur_d.left   = (x_l < cur_q.left)  ? x_l : cur_q.left;
          cur_d.right  = (x_r > cur_q.right) ? x_r : cur_q.right;
          cur_d.bottom = line_q;
          hits_d       = (hits_q == 9'h1FF) ? hits_q : hits_q + 9'd1;
          gap_d        = '0;
`ifdef RLE_BLOB_AREA_EN
          cur_area_d   = cur_area_q + 19'(run_w);
`endif
        end else begin
          gap_d = gap_inc;
        end
      end
      // Cycle after the last line: the final close above has been folded in.
      if (fin_q) begin
        valid_d = 1'b1;
        found_d = best_vld_d;
        out_d   = best_vld_d ? best_d : '0;
`ifdef RLE_BLOB_AREA_EN
        out_area_d = best_vld_d ? best_area_d : '0;
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
      fin_q      <= 1'b0;
      line_q     <= '0;
      cur_q      <= '0;
      hits_q     <= '0;
      gap_q      <= '0;
      best_q     <= '0;
      best_vld_q <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      found_q    <= 1'b0;
`ifdef RLE_BLOB_AREA_EN
      cur_area_q  <= '0;
      best_area_q <= '0;
      out_area_q  <= '0;
`endif
    end else begin
      armed_q    <= armed_d;
      done_q     <= done_d;
      fin_q      <= fin_d;
      line_q     <= line_d;
      cur_q      <= cur_d;
      hits_q     <= hits_d;
      gap_q      <= gap_d;
      best_q     <= best_d;
      best_vld_q <= best_vld_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      found_q    <= found_d;
`ifdef RLE_BLOB_AREA_EN
      cur_area_q  <= cur_area_d;
      best_area_q <= best_area_d;
      out_area_q  <= out_area_d;
`endif
    end
  end

  assign bbox_left   = out_q.left;
  assign bbox_right  = out_q.right;
  assign bbox_top    = out_q.top;
  assign bbox_bottom = out_q.bottom;
  assign bbox_valid  = valid_q;
  assign bbox_found  = found_q;
`ifdef RLE_BLOB_AREA_EN
  assign bbox_area   = out_area_q;
`endif

endmodule

// File: tb/tb_rle_blob_tracker.sv
// tb/tb_rle_blob_tracker.sv - randomized self-checking bench for rle_blob_tracker
module tb_rle_blob_tracker;

  localparam int W    = 639;
  localparam int H    = 479;
  localparam int GAP  = 3;
  localparam int MINL = 4;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       frame_start = 1'b0;
  logic       line_end = 1'b0;
  logic [9:0] run_start = '0;
  logic [9:0] run_len = '0;
  logic [9:0] bbox_left, bbox_right;
  logic [8:0] bbox_top, bbox_bottom;
  logic       bbox_valid, bbox_found;
`ifdef RLE_BLOB_AREA_EN
  logic [18:0] bbox_area;
`endif

  rle_blob_tracker #(
    .IMAGE_W(W), .IMAGE_H(H), .GAP_MAX(GAP), .MIN_LINES(MINL)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .frame_start(frame_start),
    .line_end(line_end),
    .run_start(run_start),
    .run_len(run_len),
    .bbox_left(bbox_left),
    .bbox_right(bbox_right),
    .bbox_top(bbox_top),
    .bbox_bottom(bbox_bottom),
    .bbox_valid(bbox_valid),
`ifdef RLE_BLOB_AREA_EN
    .bbox_area(bbox_area),
`endif
    .bbox_found(bbox_found)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int l; int r; int t; int b; int n; int a;
  } blob_t;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  int rs [0:H];
  int rl [0:H];
  int exp_found, exp_l, exp_r, exp_t, exp_b, exp_area;

  always @(negedge CLK) if (bbox_valid === 1'b1) valid_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_lines();
    for (int y = 0; y <= H; y++) begin
      rs[y] = $urandom_range(0, 1023);
      rl[y] = 0;
    end
  endtask

  task automatic fill(input int y0, input int y1, input int xs, input int len);
    for (int y = y0; y <= y1; y++) begin
      rs[y] = xs;
      rl[y] = len;
    end
  endtask

  // Line-level reference: split the frame into blobs, then pick the tallest
  // qualifying one (earliest wins a tie).
  task automatic model();
    blob_t q[$];
    blob_t cur;
    int open = 0;
    int miss = 0;
    int best_h = -1;
    int xl, xr;
    bit h;
    cur = '{0, 0, 0, 0, 0, 0};
    for (int y = 0; y <= H; y++) begin
      h  = (rl[y] != 0) && (rs[y] <= W);
      xl = rs[y];
      xr = (rs[y] + rl[y] - 1 > W) ? W : rs[y] + rl[y] - 1;
      if (open == 0) begin
        if (h) begin
          cur  = '{xl, xr, y, y, 1, xr - xl + 1};
          open = 1;
          miss = 0;
        end
      end else if (h && xl <= cur.r && xr >= cur.l) begin
        if (xl < cur.l) cur.l = xl;
        if (xr > cur.r) cur.r = xr;
        cur.b = y;
        cur.n++;
        cur.a += xr - xl + 1;
        miss = 0;
      end else begin
        miss++;
        if (miss == GAP) begin
          q.push_back(cur);
          open = 0;
        end
      end
    end
    if (open != 0) q.push_back(cur);
    exp_found = 0; exp_l = 0; exp_r = 0; exp_t = 0; exp_b = 0; exp_area = 0;
    foreach (q[i]) begin
      if (q[i].n >= MINL && (q[i].b - q[i].t) > best_h) begin
        best_h = q[i].b - q[i].t;
        exp_found = 1; exp_l = q[i].l; exp_r = q[i].r;
        exp_t = q[i].t; exp_b = q[i].b; exp_area = q[i].a;
      end
    end
  endtask

  task automatic send_lines(input bit do_fs, input bit fs_le, input int last_line);
    if (do_fs) begin
      @(negedge CLK);
      frame_start = 1'b1;
      if (fs_le) begin
        line_end  = 1'b1;
        run_start = 10'd50;
        run_len   = 10'd60;
      end
      @(negedge CLK);
      frame_start = 1'b0;
      line_end    = 1'b0;
    end
    for (int y = 0; y <= last_line; y++) begin
      line_end  = 1'b1;
      run_start = 10'(rs[y]);
      run_len   = 10'(rl[y]);
      @(negedge CLK);
      line_end  = 1'b0;
      run_start = 10'($urandom);
      run_len   = 10'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_found"},  bbox_found,  exp_found);
    check_eq({tag, "_left"},   bbox_left,   exp_l);
    check_eq({tag, "_right"},  bbox_right,  exp_r);
    check_eq({tag, "_top"},    bbox_top,    exp_t);
    check_eq({tag, "_bottom"}, bbox_bottom, exp_b);
`ifdef RLE_BLOB_AREA_EN
    check_eq({tag, "_area"},   bbox_area,   exp_area);
`endif
  endtask

  task automatic wait_result(input string tag, input int v0);
    int k = 0;
    while (valid_cnt == v0 && k < 30) begin
      @(negedge CLK);
      k++;
    end
    if (valid_cnt == v0) check_eq({tag, "_valid_timeout"}, 0, 1);
    repeat (5) @(negedge CLK);
    check_eq({tag, "_pulses"}, valid_cnt - v0, 1);
    check_outputs(tag);
  endtask

  task automatic run_frame(input string tag, input bit fs_le);
    int v0;
    model();
    v0 = valid_cnt;
    send_lines(1'b1, fs_le, H);
    wait_result(tag, v0);
  endtask

  task automatic gen_random();
    int nobj, top, ht, x0, w;
    clear_lines();
    nobj = $urandom_range(1, 4);
    for (int k = 0; k < nobj; k++) begin
      top = $urandom_range(0, H);
      ht  = $urandom_range(1, 60);
      x0  = $urandom_range(0, 660);
      w   = $urandom_range(1, 150);
      for (int y = top; y <= top + ht && y <= H; y++) begin
        if ($urandom_range(0, 7) == 0) rl[y] = 0;
        else begin
          rs[y] = x0 + $urandom_range(0, 10);
          rl[y] = w;
        end
      end
    end
    for (int k = 0; k < 10; k++) begin
      top = $urandom_range(0, H);
      rs[top] = $urandom_range(0, 1023);
      rl[top] = $urandom_range(0, 1023);
    end
  endtask

  initial begin
    int v0;
    // Reset values and line_end ignored before the first frame_start.
    repeat (3) @(negedge CLK);
    check_eq("rst_valid", bbox_valid, 0);
    check_eq("rst_found", bbox_found, 0);
    check_eq("rst_left", bbox_left, 0);
    check_eq("rst_right", bbox_right, 0);
    check_eq("rst_top", bbox_top, 0);
    check_eq("rst_bottom", bbox_bottom, 0);
    RESET_N = 1'b1;
    clear_lines();
    fill(0, H, 10, 10);
    v0 = valid_cnt;
    send_lines(1'b0, 1'b0, H);
    send_lines(1'b0, 1'b0, 5);
    repeat (10) @(negedge CLK);
    check_eq("unarmed_pulses", valid_cnt - v0, 0);
    check_eq("unarmed_found", bbox_found, 0);

    // Single blob, then extra line_ends after the last line are ignored.
    clear_lines(); fill(100, 119, 200, 50);
    run_frame("single", 1'b0);
    check_eq("single_const_r", bbox_right, 249);
    check_eq("single_const_b", bbox_bottom, 119);
    v0 = valid_cnt;
    send_lines(1'b0, 1'b0, 8);
    repeat (10) @(negedge CLK);
    check_eq("post_last_pulses", valid_cnt - v0, 0);
    check_outputs("post_last");

    clear_lines(); fill(10, 15, 100, 20); fill(17, 22, 100, 20);
    run_frame("gap", 1'b0);
    check_eq("gap_const_b", bbox_bottom, 22);

    clear_lines(); fill(10, 13, 0, 10); fill(50, 79, 300, 100);
    run_frame("two", 1'b1);
    check_eq("two_const_l", bbox_left, 300);

    clear_lines(); fill(30, 32, 40, 40);
    run_frame("reject", 1'b0);
    check_eq("reject_const_found", bbox_found, 0);

    clear_lines(); fill(5, 10, 600, 100);
    run_frame("clip", 1'b0);
    check_eq("clip_const_r", bbox_right, 639);

    // Abort at line 200: no strobe, outputs held, old best discarded.
    clear_lines(); fill(20, 150, 100, 100); fill(190, 260, 400, 50);
    v0 = valid_cnt;
    send_lines(1'b1, 1'b0, 199);
    frame_start = 1'b1;
    @(negedge CLK);
    frame_start = 1'b0;
    repeat (20) @(negedge CLK);
    check_eq("abort_pulses", valid_cnt - v0, 0);
    check_outputs("abort_hold");
    clear_lines(); fill(300, 310, 50, 30);
    model();
    v0 = valid_cnt;
    send_lines(1'b0, 1'b0, H);
    wait_result("after_abort", v0);

    for (int f = 0; f < 8; f++) begin
      gen_random();
      run_frame($sformatf("rand%0d", f), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset clears outputs without a clock edge.
    clear_lines(); fill(100, 119, 200, 50);
    run_frame("final", 1'b0);
    #2;
    RESET_N = 1'b0;
    #1;
    check_eq("async_found", bbox_found, 0);
    check_eq("async_left", bbox_left, 0);
    check_eq("async_bottom", bbox_bottom, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
